round_robin_arbiter_4: RTL and testbench
========================================

ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 8, maximum consecutive cycles a single grant is held; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 SHALL have port: gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-006 SHALL have port: gnt_id  output  2  binary index of the set bit of gnt; 0 when gnt is all-zero.
REQ-007 SHALL have port: none  output  1  high exactly when gnt is all-zero.
REQ-008 SHALL have port: timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-010 SHALL keep a 2-bit priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-011 In IDLE with req != 0, SHALL select the first requester in search order and, at the next edge, set gnt to its one-hot code, gnt_id to its index, none=0 and enter GRANT (latency 1 cycle).
REQ-012 In IDLE with req == 0, SHALL remain in IDLE with gnt=0, none=1.
REQ-013 SHALL keep gnt, gnt_id and none stable throughout GRANT; other req bits SHALL NOT affect them.
REQ-014 SHALL count hold cycles with a counter of width $clog2(MAX_HOLD+1); the counter is 1 in the first GRANT cycle and increments each further GRANT cycle.
REQ-015 In GRANT with req[gnt_id]=0 sampled, SHALL at the next edge clear gnt, set none=1, set ptr=gnt_id+1 mod 4 and enter IDLE (normal release).
REQ-016 In GRANT with req[gnt_id]=1 and hold count == MAX_HOLD, SHALL at the next edge clear gnt, set ptr=gnt_id+1 mod 4, enter IDLE and assert timeout for exactly that one cycle (forced release).
REQ-017 When normal and forced release conditions coincide, SHALL treat the event as a normal release (timeout stays 0).
REQ-018 Every release SHALL be followed by at least one IDLE cycle with none=1 before the next grant; no back-to-back grant without that gap.
REQ-019 A requester dropping req while not granted SHALL have no effect; requests are not latched.
REQ-020 ptr SHALL change only on a release; it SHALL wrap 3 -> 0.
REQ-021 gnt SHALL never have more than one bit set; gnt_id and none SHALL always agree with gnt.

Reset
REQ-022 With rst=1 at an edge, SHALL set state=IDLE, ptr=0, hold count=0, gnt=4'b0000, gnt_id=0, none=1, timeout=0, regardless of state (including mid-GRANT).
REQ-023 rst SHALL take priority over all other conditions; the first grant may occur on the edge after the first edge with rst=0 and req != 0.

Verification
REQ-024 After reset, req=4'b1010 held -> one edge later gnt=4'b0010, gnt_id=1, none=0.
REQ-025 req=4'b0001 for 3 grant cycles then 4'b0000 -> gnt=4'b0001 for 3 cycles, then gnt=0, none=1, timeout=0, ptr=1.
REQ-026 MAX_HOLD=8, req=4'b1111 constant from reset -> grants 0,1,2,3,0 in order, each exactly 8 cycles, a 1-cycle gap between grants, timeout high once in each gap.
REQ-027 After release of requester 2 (ptr=3), req=4'b0101 -> gnt=4'b0001 (requester 0 wins over 2).
REQ-028 rst=1 asserted in the 4th cycle of a grant to requester 3 -> next edge gnt=0, gnt_id=0, none=1, timeout=0; after rst=0 with req=4'b1000 -> gnt=4'b1000 (ptr back to 0).
REQ-029 Throughout all scenarios, assert gnt one-hot-or-zero, none == (gnt == 0), and gnt_id consistent with gnt every cycle.

Source files
------------

// File: rtl/round_robin_arbiter_4.sv
// Four-way round-robin arbiter with a registered one-hot grant and a bounded hold time.
// A holder that keeps requesting is forced off after MAX_HOLD cycles, and timeout pulses once.
module round_robin_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       none,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state_q,   state_d;
  logic [1:0]    ptr_q,     ptr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [3:0]    gnt_q,     gnt_d;
  logic [1:0]    gnt_id_q,  gnt_id_d;
  logic          none_q,    none_d;
  logic          timeout_q, timeout_d;

  // Requests rotated so that bit 0 is the requester the pointer currently favours.
  logic [3:0] req_rot;
  logic [1:0] win_off;
  logic [1:0] win_id;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = req[ptr_q + 2'(gi)];
  end

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) win_off = 2'(k);
    end
  end

  assign win_id = ptr_q + win_off;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    none_d    = none_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          state_d  = S_GRANT;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          none_d   = 1'b0;
          cnt_d    = CW'(1);
        end
      end
      S_GRANT: begin
        // A dropped request wins over an expired hold, so timeout only fires
        // when the holder is still asking for the resource.
        if (!req[gnt_id_q] || (cnt_q == HOLD_MAX)) begin
          state_d   = S_IDLE;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          none_d    = 1'b1;
          cnt_d     = '0;
          ptr_d     = gnt_id_q + 2'd1;
          timeout_d = req[gnt_id_q];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        none_d   = 1'b1;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      none_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      none_q    <= none_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign none    = none_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Bench for round_robin_arbiter_4: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an owner/hold-count model.
module tb_round_robin_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       none;
  logic       timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  round_robin_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .none    (none),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: who owns the resource (-1 = nobody), how long, and whose turn is next.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  int m_to    = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_hold  = 1;
        end
      end
    end else if (!req[m_owner] || m_hold == MAX_HOLD) begin
      m_to    = req[m_owner] ? 1 : 0;
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_hold  = 0;
    end else begin
      m_hold++;
    end
    #1;
    chk("model_gnt", {28'd0, gnt}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("model_gnt_id", {30'd0, gnt_id}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_none", {31'd0, none}, (m_owner < 0) ? 32'd1 : 32'd0);
    chk("model_timeout", {31'd0, timeout}, 32'(m_to));
    chk("onehot", {31'd0, $onehot0(gnt)}, 32'd1);
    chk("none_consistent", {31'd0, none}, {31'd0, (gnt == 4'b0000)});
    chk("id_consistent", {28'd0, gnt}, (gnt == 4'b0000) ? 32'd0 : (32'd1 << gnt_id));
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    nclk(1);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset values
    nclk(2);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_gnt_id", {30'd0, gnt_id}, 32'd0);
    chk("rst_none", {31'd0, none}, 32'd1);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);

    // Lowest requester from ptr=0 with 1010 is 1
    rst = 1'b0; req = 4'b1010;
    nclk(1);
    chk("first_gnt", {28'd0, gnt}, 32'h2);
    chk("first_id", {30'd0, gnt_id}, 32'd1);
    chk("first_none", {31'd0, none}, 32'd0);

    // Three grant cycles to requester 0, normal release, then ptr=1 picks 1
    do_reset();
    rst = 1'b0; req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      nclk(1);
      chk("hold3_gnt", {28'd0, gnt}, 32'h1);
    end
    req = 4'b0000;
    nclk(1);
    chk("rel_gnt", {28'd0, gnt}, 32'h0);
    chk("rel_none", {31'd0, none}, 32'd1);
    chk("rel_timeout", {31'd0, timeout}, 32'd0);
    req = 4'b1111;
    nclk(1);
    chk("ptr1_gnt", {28'd0, gnt}, 32'h2);

    // All requesting: 0,1,2,3,0 each for MAX_HOLD cycles, one-cycle gap with timeout
    do_reset();
    req = 4'b1111;
    rst = 1'b0;
    foreach (order[o]) begin
      for (int k = 0; k < MAX_HOLD; k++) begin
        nclk(1);
        chk("rr_gnt", {28'd0, gnt}, 32'd1 << order[o]);
        chk("rr_timeout", {31'd0, timeout}, 32'd0);
      end
      nclk(1);
      chk("gap_gnt", {28'd0, gnt}, 32'h0);
      chk("gap_none", {31'd0, none}, 32'd1);
      chk("gap_timeout", {31'd0, timeout}, 32'd1);
    end

    // Release of 2 leaves ptr=3, so 0 beats 2
    do_reset();
    rst = 1'b0; req = 4'b0100;
    nclk(1);
    chk("g2_gnt", {28'd0, gnt}, 32'h4);
    req = 4'b0000;
    nclk(1);
    req = 4'b0101;
    nclk(1);
    chk("ptr3_gnt", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    nclk(1);

    // Reset in the 4th grant cycle of requester 3, then pointer is back at 0
    req = 4'b1000;
    nclk(1);
    chk("g3_gnt", {28'd0, gnt}, 32'h8);
    nclk(3);
    rst = 1'b1;
    nclk(1);
    chk("midrst_gnt", {28'd0, gnt}, 32'h0);
    chk("midrst_id", {30'd0, gnt_id}, 32'd0);
    chk("midrst_none", {31'd0, none}, 32'd1);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0; req = 4'b1001;
    nclk(1);
    chk("ptr0_gnt", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    nclk(1);
    do_reset();
    rst = 1'b0; req = 4'b1000;
    nclk(1);
    chk("after_rst_gnt", {28'd0, gnt}, 32'h8);

    // Randomized traffic with slowly changing requests so forced releases occur
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
